axi4_burst_mem: RTL
===================

AXI4_BURST_MEM -- requirements
Module: axi4_burst_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, beat width in bits (multiple of 8, power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_SIZE_BYTES, default 4096, storage size (power of two, multiple of DATA_WIDTH/8).
REQ-004 SHALL have port axi_clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port axi_resetn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port axi_araddr, input, ADDR_WIDTH, read burst start byte address.
REQ-007 SHALL have port axi_arlen, input, 8, read beats minus one.
REQ-008 SHALL have port axi_arvalid, input, 1, read address valid.
REQ-009 SHALL have port axi_arready, output, 1, read address accepted.
REQ-010 SHALL have port axi_rdata, output, DATA_WIDTH, read beat data.
REQ-011 SHALL have port axi_rresp, output, 2, read beat response.
REQ-012 SHALL have port axi_rlast, output, 1, final read beat.
REQ-013 SHALL have port axi_rvalid, output, 1, read beat valid.
REQ-014 SHALL have port axi_rready, input, 1, master accepts read beat.
REQ-015 SHALL have port axi_awaddr, input, ADDR_WIDTH, write burst start byte address.
REQ-016 SHALL have port axi_awlen, input, 8, write beats minus one.
REQ-017 SHALL have port axi_awvalid, input, 1, write address valid.
REQ-018 SHALL have port axi_awready, output, 1, write address accepted.
REQ-019 SHALL have port axi_wdata, input, DATA_WIDTH, write beat data.
REQ-020 SHALL have port axi_wstrb, input, DATA_WIDTH/8, byte-lane write enables.
REQ-021 SHALL have port axi_wlast, input, 1, master's final-beat marker.
REQ-022 SHALL have port axi_wvalid, input, 1, write beat valid.
REQ-023 SHALL have port axi_wready, output, 1, slave accepts write beat.
REQ-024 SHALL have port axi_bresp, output, 2, write response code.
REQ-025 SHALL have port axi_bvalid, output, 1, write response valid.
REQ-026 SHALL have port axi_bready, input, 1, master accepts response.

Function
REQ-027 Word index SHALL be addr >> log2(DATA_WIDTH/8); low address bits ignored; beat i uses index+i (INCR only).
REQ-028 Read FSM SHALL be R_IDLE (arready=1) -> R_DATA on arvalid&arready, capturing address and arlen; arready=0 outside R_IDLE.
REQ-029 First rvalid SHALL assert the cycle after the AR handshake; rdata/rresp/rlast SHALL hold stable while rvalid&!rready.
REQ-030 Each rvalid&rready SHALL advance the beat; rlast=1 exactly on beat arlen; after that handshake FSM returns to R_IDLE, rvalid=0.
REQ-031 Write FSM SHALL be W_IDLE (awready=1) -> W_DATA (wready=1) -> W_RESP (bvalid=1) -> W_IDLE on bvalid&bready.
REQ-032 Each wvalid&wready SHALL write only byte lanes with wstrb set; after beat awlen, FSM enters W_RESP, wready=0.
REQ-033 If wlast disagrees with beat==awlen on any beat, bresp SHALL be SLVERR (2'b10); data still written; otherwise OKAY (2'b00).
REQ-034 Read and write FSMs SHALL run independently; same-cycle read beat and write to one word returns pre-write data.
REQ-035 Burst length 1 (len=0) SHALL give a single beat with rlast=1.

Reset
REQ-036 Assertion of axi_resetn low SHALL immediately force: FSMs idle, arready/awready/wready/rvalid/bvalid/rlast=0, rdata=0, rresp/bresp=0; in-flight bursts abandoned; memory contents not cleared.
REQ-037 After deassertion, arready and awready SHALL assert on the first rising edge.

Configuration
REQ-038 With AXI_MEM_RANGE_CHECK_EN defined, beats with index >= MEM_SIZE_BYTES/(DATA_WIDTH/8) SHALL return rdata=0 with rresp DECERR (2'b11) and writes SHALL be dropped with bresp DECERR.
REQ-039 Without AXI_MEM_RANGE_CHECK_EN, index SHALL wrap modulo depth and DECERR SHALL never be issued.

Structure
REQ-040 Package axi4_pkg SHALL hold resp constants (OKAY, SLVERR, DECERR) and the read/write state enums.
REQ-041 Storage SHALL be a sub-module mem_byte_ram (byte-strobed synchronous write, combinational read).

Verification
REQ-042 Write 0x11223344 to 0x10 (len 0, strb 4'hF), read 0x10 -> rdata 0x11223344, rresp 0, rlast 1, bresp 0.
REQ-043 Write 4-beat burst 1,2,3,4 at 0x40, read len 3 with rready toggling every cycle -> 1,2,3,4 in order, rlast only on 4th, data stable while stalled.
REQ-044 Write 0xAABBCCDD, then strb 4'b0010 data 0x0000EE00 same address -> read 0xAABBEEDD.
REQ-045 Write len 1 with wlast on beat 0 -> bresp 2'b10; both beats written.
REQ-046 Read address 0x1000 (depth 1024 words): with macro -> rdata 0, rresp 2'b11; without -> data of address 0x0.
REQ-047 Drop axi_resetn mid 8-beat read -> rvalid 0 at once; new read after release completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared definitions for the AXI4 burst memory slave:
//   - AXI response codes (OKAY, SLVERR, DECERR)
//   - read and write channel FSM state enums
//   - helper that folds accumulated write-burst error flags into a BRESP code
// -----------------------------------------------------------------------------
package axi4_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // A decode error outranks a protocol (wlast) error.
    function automatic logic [1:0] wr_resp(input logic dec_err, input logic slv_err);
        if (dec_err) begin
            return DECERR;
        end else if (slv_err) begin
            return SLVERR;
        end
        return OKAY;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// -----------------------------------------------------------------------------
// mem_byte_ram
// Word-organised storage with per-byte write enables.
//   clk    : write clock (rising edge)
//   we     : write enable for this cycle
//   waddr  : word index written
//   wstrb  : byte lanes written when we=1
//   wdata  : write word
//   raddr  : word index read
//   rdata  : combinational read of raddr (shows contents before this cycle's write)
// Contents are deliberately not reset.
// -----------------------------------------------------------------------------
module mem_byte_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (we && wstrb[b]) begin
                mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi4_burst_mem.sv
// -----------------------------------------------------------------------------
// axi4_burst_mem
// AXI4 slave (INCR bursts only) backed by a byte-strobed RAM.
//   axi_clk / axi_resetn      : clock, asynchronous active-low reset
//   axi_ar* / axi_r*          : read address and read data channels
//   axi_aw* / axi_w* / axi_b* : write address, write data, write response
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both 1; the sender holds its payload steady while valid
// is high and ready is low.
// The read and write FSMs are independent. Read data is registered when a beat
// is launched, so a write landing in the same cycle is not seen by that beat.
// Build option: define AXI_MEM_RANGE_CHECK_EN to answer beats beyond the
// storage depth with DECERR (reads return 0, writes dropped); without it the
// word index wraps modulo the depth.
// -----------------------------------------------------------------------------
module axi4_burst_mem
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_SIZE_BYTES = 4096
) (
    input  logic                    axi_clk,
    input  logic                    axi_resetn,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]              axi_arlen,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int DEPTH      = MEM_SIZE_BYTES / STRB_W;
    localparam int IDX_W      = $clog2(DEPTH);

    // ---------------- read channel state ----------------
    r_state_e                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0]   r_idx_q, r_idx_d;
    logic [7:0]              r_len_q, r_len_d;
    logic [7:0]              r_beat_q, r_beat_d;

    // ---------------- write channel state ----------------
    w_state_e                w_state_q, w_state_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0]   w_idx_q, w_idx_d;
    logic [7:0]              w_len_q, w_len_d;
    logic [7:0]              w_beat_q, w_beat_d;
    logic                    slv_err_q, slv_err_d;
    logic                    dec_err_q, dec_err_d;

    // ---------------- datapath ----------------
    logic [ADDR_WIDTH-1:0]   ar_idx, aw_idx, rd_idx;
    logic [DATA_WIDTH-1:0]   mem_rdata, rd_beat_data;
    logic [1:0]              rd_beat_resp;
    logic                    rd_oob, wr_oob, mem_we;

    assign ar_idx = axi_araddr >> BYTE_SHIFT;
    assign aw_idx = axi_awaddr >> BYTE_SHIFT;

    // The RAM read port looks at the beat about to be launched: the first beat
    // straight off the AR bus while idle, otherwise the beat after the current.
    assign rd_idx = (r_state_q == R_IDLE) ? ar_idx : (r_idx_q + ADDR_WIDTH'(1));

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign rd_oob = (rd_idx >= ADDR_WIDTH'(DEPTH));
    assign wr_oob = (w_idx_q >= ADDR_WIDTH'(DEPTH));
`else
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
`endif

    // Upper index bits only matter for the range check; the RAM wraps.
    logic unused_idx_hi;
    assign unused_idx_hi = ^{rd_idx[ADDR_WIDTH-1:IDX_W], w_idx_q[ADDR_WIDTH-1:IDX_W]};

    assign rd_beat_data = rd_oob ? '0 : mem_rdata;
    assign rd_beat_resp = rd_oob ? DECERR : OKAY;

    mem_byte_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk   (axi_clk),
        .we    (mem_we),
        .waddr (w_idx_q[IDX_W-1:0]),
        .wstrb (axi_wstrb),
        .wdata (axi_wdata),
        .raddr (rd_idx[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    // ---------------- read FSM ----------------
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    r_idx_d   = ar_idx;
                    r_len_d   = axi_arlen;
                    r_beat_d  = 8'd0;
                    rlast_d   = (axi_arlen == 8'd0);
                    rdata_d   = rd_beat_data;
                    rresp_d   = rd_beat_resp;
                end
            end
            R_DATA: begin
                if (rvalid_q && axi_rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        r_idx_d  = r_idx_q + ADDR_WIDTH'(1);
                        r_beat_d = r_beat_q + 8'd1;
                        rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
                        rdata_d  = rd_beat_data;
                        rresp_d  = rd_beat_resp;
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_beat_q  <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
        end
    end

    // ---------------- write FSM ----------------
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        slv_err_d = slv_err_q;
        dec_err_d = dec_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi_awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_idx_d   = aw_idx;
                    w_len_d   = axi_awlen;
                    w_beat_d  = 8'd0;
                    slv_err_d = 1'b0;
                    dec_err_d = 1'b0;
                end
            end
            W_DATA: begin
                if (axi_wvalid && wready_q) begin
                    mem_we = !wr_oob;
                    // A misplaced wlast is flagged but the data is still stored.
                    slv_err_d = slv_err_q | (axi_wlast != (w_beat_q == w_len_q));
                    dec_err_d = dec_err_q | wr_oob;
                    w_idx_d   = w_idx_q + ADDR_WIDTH'(1);
                    w_beat_d  = w_beat_q + 8'd1;
                    if (w_beat_q == w_len_q) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = wr_resp(dec_err_d, slv_err_d);
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_beat_q  <= 8'd0;
            slv_err_q <= 1'b0;
            dec_err_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            slv_err_q <= slv_err_d;
            dec_err_q <= dec_err_d;
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;

endmodule
